// File: rtl/prog_loader.sv
// Serial program loader: receives 8N1 bytes on rxd, fills a 16x8 program memory,
// verifies an additive checksum and releases the CPU from reset once the image is good.
module prog_loader #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic [3:0] pc,
  output logic [7:0] instr,
  output logic       cpu_reset_n,
  output logic       busy,
  output logic       err
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLK_DIV / 2 - 1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, RUN} state_t;

  // ---------------------------------------------------------------- receiver
  logic rx_s1, rx_s2, rx_prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  rx_state_t       rx_state, rx_state_n;
  logic [CW-1:0]   rx_cnt, rx_cnt_n;
  logic [2:0]      rx_bit, rx_bit_n;
  logic [7:0]      rx_shift, rx_shift_n;
  logic            byte_valid, byte_valid_n;
  logic            frame_err, frame_err_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_bit     <= rx_bit_n;
      rx_shift   <= rx_shift_n;
      byte_valid <= byte_valid_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt;
    rx_bit_n     = rx_bit;
    rx_shift_n   = rx_shift;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_state_n = RX_START;
          rx_cnt_n   = HALF_CNT;
        end
      end
      RX_START: begin
        // Mid-start-bit re-sample rejects glitches shorter than half a bit.
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - 1'b1;
        end else if (rx_s2) begin
          rx_state_n = RX_IDLE;
        end else begin
          rx_state_n = RX_DATA;
          rx_cnt_n   = FULL_CNT;
          rx_bit_n   = '0;
        end
      end
      RX_DATA: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - 1'b1;
        end else begin
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_cnt_n   = FULL_CNT;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - 1'b1;
        end else begin
          rx_state_n = RX_IDLE;
          if (rx_s2) byte_valid_n = 1'b1;
          else       frame_err_n  = 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- control
  state_t     state, state_n;
  logic [3:0] addr, addr_n;
  logic [7:0] checksum, checksum_n;
  logic       err_n;
  logic       mem_we;
  logic [7:0] mem [16];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      addr        <= '0;
      checksum    <= '0;
      err         <= 1'b0;
      cpu_reset_n <= 1'b0;
    end else begin
      state       <= state_n;
      addr        <= addr_n;
      checksum    <= checksum_n;
      err         <= err_n;
      cpu_reset_n <= (state_n == RUN);
    end
  end

  always_comb begin
    state_n    = state;
    addr_n     = addr;
    checksum_n = checksum;
    err_n      = err;
    mem_we     = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (byte_valid && rx_shift == SYNC_BYTE) begin
          state_n    = LOAD;
          addr_n     = '0;
          checksum_n = '0;
          err_n      = 1'b0;
        end
      end
      LOAD: begin
        if (frame_err) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else if (byte_valid) begin
          mem_we     = 1'b1;
          checksum_n = checksum + rx_shift;
          if (addr == 4'd15) state_n = CHECK;
          else               addr_n  = addr + 4'd1;
        end
      end
      CHECK: begin
        if (frame_err) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else if (byte_valid) begin
          if (rx_shift == checksum) begin
            state_n = RUN;
          end else begin
            state_n = IDLE;
            err_n   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Memory has no reset so a CPU reset cycle keeps the loaded program.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[addr] <= rx_shift;
  end

  assign instr = mem[pc];
  assign busy  = (state == LOAD) || (state == CHECK);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: drives serial bytes on rxd and compares
// status flags and program memory against a scoreboard of expected values.
module tb_prog_loader;

  localparam int CLK_DIV = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic [3:0] pc = '0;
  logic [7:0] instr;
  logic       cpu_reset_n, busy, err;

  prog_loader #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .pc(pc),
    .instr(instr), .cpu_reset_n(cpu_reset_n), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         pc;   // -1: compare {busy,cpu_reset_n,err}; else instr at this pc
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] data [16];
  logic [7:0] sum;

  function automatic logic [7:0] fl(input logic b, input logic c, input logic e);
    return {5'b0, b, c, e};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_flags(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag; e.pc = -1; e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_mem(input string tag, input int a, input logic [7:0] v);
    exp_t e;
    e.tag = tag; e.pc = a; e.val = v;
    sb.push_back(e);
  endtask

  // Called just after a falling edge so samples stay clear of the rising edge.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.pc < 0) begin
        check(e.tag, fl(busy, cpu_reset_n, err), e.val);
      end else begin
        pc = 4'(e.pc);
        #1;
        check(e.tag, instr, e.val);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input string tag, input logic [7:0] exp);
    push_flags(tag, exp);
    @(negedge clk) rxd = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (CLK_DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    drain();
  endtask

  task automatic check_all_mem(input string tag);
    for (int i = 0; i < 16; i++) push_mem(tag, i, data[i]);
    drain();
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    push_flags("reset_flags", fl(0, 0, 0));
    drain();
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Full load 00..0F with checksum 78
    send_byte(8'hA5, 1'b1, "load1_sync", fl(1, 0, 0));
    for (int i = 0; i < 16; i++) begin
      data[i] = 8'(i);
      send_byte(data[i], 1'b1, "load1_data", fl(1, 0, 0));
    end
    send_byte(8'h78, 1'b1, "load1_sum", fl(0, 1, 0));
    push_mem("load1_pc9", 9, 8'h09);
    drain();
    check_all_mem("load1_mem");

    // Bad checksum: 16 x FF then 00 (expected F0)
    send_byte(8'hA5, 1'b1, "bad_sync", fl(1, 0, 0));
    for (int i = 0; i < 16; i++) begin
      data[i] = 8'hFF;
      send_byte(8'hFF, 1'b1, "bad_data", fl(1, 0, 0));
    end
    send_byte(8'h00, 1'b1, "bad_sum", fl(0, 0, 1));
    push_mem("bad_mem15", 15, 8'hFF);
    drain();
    send_byte(8'h78, 1'b1, "bad_idle_ignore", fl(0, 0, 1));

    // Framing error during load
    send_byte(8'hA5, 1'b1, "frm_sync_clears_err", fl(1, 0, 0));
    send_byte(8'h11, 1'b1, "frm_d0", fl(1, 0, 0));
    send_byte(8'h22, 1'b1, "frm_d1", fl(1, 0, 0));
    send_byte(8'h33, 1'b1, "frm_d2", fl(1, 0, 0));
    send_byte(8'h44, 1'b0, "frm_stop_low", fl(0, 0, 1));
    send_byte(8'h55, 1'b1, "frm_ignore", fl(0, 0, 1));
    send_byte(8'h00, 1'b1, "frm_ignore_zero", fl(0, 0, 1));
    send_byte(8'h66, 1'b0, "frm_idle_frame_err", fl(0, 0, 1));
    push_mem("frm_mem0", 0, 8'h11);
    push_mem("frm_mem2", 2, 8'h33);
    push_mem("frm_mem3_kept", 3, 8'hFF);
    drain();

    // False start glitch between bytes while loading
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      data[i] = 8'(i * 7 + 3);
      sum = sum + data[i];
    end
    send_byte(8'hA5, 1'b1, "fs_sync", fl(1, 0, 0));
    for (int i = 0; i < 3; i++) send_byte(data[i], 1'b1, "fs_data", fl(1, 0, 0));
    @(negedge clk) rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    push_flags("fs_after_glitch", fl(1, 0, 0));
    drain();
    for (int i = 3; i < 16; i++) send_byte(data[i], 1'b1, "fs_data", fl(1, 0, 0));
    send_byte(sum, 1'b1, "fs_sum", fl(0, 1, 0));
    check_all_mem("fs_mem");

    // Run-state behaviour and reload
    send_byte(8'h44, 1'b0, "run_frame_err", fl(0, 1, 0));
    send_byte(8'h5A, 1'b1, "run_ignore", fl(0, 1, 0));
    send_byte(8'hA5, 1'b1, "reload_sync", fl(1, 0, 0));
    for (int i = 0; i < 16; i++) begin
      data[i] = 8'h01;
      send_byte(8'h01, 1'b1, "reload_data", fl(1, 0, 0));
      if (i == 0) begin
        push_mem("reload_write_visible", 0, 8'h01);
        drain();
      end
    end
    send_byte(8'h10, 1'b1, "reload_sum", fl(0, 1, 0));
    check_all_mem("reload_mem");

    // Reset mid-load, partway through the 6th data byte
    send_byte(8'hA5, 1'b1, "rst_sync", fl(1, 0, 0));
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 1'b1, "rst_data", fl(1, 0, 0));
    @(negedge clk) rxd = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (CLK_DIV) @(negedge clk);
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    push_flags("rst_flags", fl(0, 0, 0));
    push_mem("rst_mem_kept0", 0, 8'hC0);
    push_mem("rst_mem_kept4", 4, 8'hC4);
    push_mem("rst_mem_kept5", 5, 8'h01);
    drain();
    reset = 1'b1;
    repeat (20) @(negedge clk);

    sum = '0;
    for (int i = 0; i < 16; i++) begin
      data[i] = 8'(i * 29 + 5);
      sum = sum + data[i];
    end
    send_byte(8'hA5, 1'b1, "post_rst_sync", fl(1, 0, 0));
    for (int i = 0; i < 16; i++) send_byte(data[i], 1'b1, "post_rst_data", fl(1, 0, 0));
    send_byte(sum, 1'b1, "post_rst_sum", fl(0, 1, 0));
    check_all_mem("post_rst_mem");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
